// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with fixed-priority or round-robin selection
// and a valid/ready output stage that a downstream consumer can stall.
module prio_encoder_rr #(
  parameter int N    = 8,
  parameter int W    = $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         none
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic         r_valid;
  logic         r_none;
  logic [W-1:0] r_idx;
  logic [W-1:0] r_ptr;
  logic [N-1:0] r_onehot;

  logic         w_load;
  logic         w_xfer;
  logic         w_any;
  logic [W-1:0] w_ptr_next;
  logic [W-1:0] w_g_fp;
  logic [W-1:0] w_g_rr;
  logic [W-1:0] w_g;

  // Handshake: a grant transfers on any cycle with out_valid && out_ready; a new
  // req sample is taken whenever the output register is empty or being drained.
  assign w_xfer = r_valid && out_ready;
  assign w_load = !r_valid || out_ready;
  assign w_any  = |req;

  // The served index drops to lowest priority, so a back-to-back load already rotates.
  assign w_ptr_next = w_xfer ? ((r_idx == '0) ? LAST : r_idx - 1'b1) : r_ptr;

  always_comb begin : fixed_sel
    logic found;
    found  = 1'b0;
    w_g_fp = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && req[i]) begin
        w_g_fp = W'(i);
        found  = 1'b1;
      end
    end
  end

  // Downward search from the pointer, wrapping mod N (not mod 2^W).
  always_comb begin : rr_sel
    logic found;
    int   p;
    found  = 1'b0;
    p      = 0;
    w_g_rr = '0;
    for (int k = 0; k < N; k++) begin
      p = (int'(w_ptr_next) + N - k) % N;
      if (!found && req[p]) begin
        w_g_rr = W'(p);
        found  = 1'b1;
      end
    end
  end

  assign w_g = (MODE == 1) ? w_g_rr : w_g_fp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b1;
      r_ptr    <= LAST;
    end else begin
      if (w_xfer) begin
        r_ptr <= w_ptr_next;
      end
      if (w_load) begin
        r_valid <= w_any;
        r_none  <= !w_any;
        if (w_any) begin
          r_idx    <= w_g;
          r_onehot <= {{(N-1){1'b0}}, 1'b1} << w_g;
        end else begin
          r_onehot <= '0;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign idx       = r_idx;
  assign onehot    = r_onehot;
  assign none      = r_none;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed scoreboard bench: four encoder instances (fixed N=4/N=8, round-robin N=4/N=5)
// with expected outputs queued at drive time and checked by a separate monitor.
module tb_prio_encoder_rr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] a_req = '0; logic a_rdy = 1'b0; logic a_valid, a_none; logic [1:0] a_idx; logic [3:0] a_oh;
  logic [7:0] b_req = '0; logic b_rdy = 1'b0; logic b_valid, b_none; logic [2:0] b_idx; logic [7:0] b_oh;
  logic [3:0] c_req = '0; logic c_rdy = 1'b0; logic c_valid, c_none; logic [1:0] c_idx; logic [3:0] c_oh;
  logic [4:0] d_req = '0; logic d_rdy = 1'b0; logic d_valid, d_none; logic [2:0] d_idx; logic [4:0] d_oh;

  prio_encoder_rr #(.N(4), .MODE(0)) u_a (.clk(clk), .rst(rst), .req(a_req), .out_ready(a_rdy),
    .out_valid(a_valid), .idx(a_idx), .onehot(a_oh), .none(a_none));
  prio_encoder_rr #(.N(8), .MODE(0)) u_b (.clk(clk), .rst(rst), .req(b_req), .out_ready(b_rdy),
    .out_valid(b_valid), .idx(b_idx), .onehot(b_oh), .none(b_none));
  prio_encoder_rr #(.N(4), .MODE(1)) u_c (.clk(clk), .rst(rst), .req(c_req), .out_ready(c_rdy),
    .out_valid(c_valid), .idx(c_idx), .onehot(c_oh), .none(c_none));
  prio_encoder_rr #(.N(5), .MODE(1)) u_d (.clk(clk), .rst(rst), .req(d_req), .out_ready(d_rdy),
    .out_valid(d_valid), .idx(d_idx), .onehot(d_oh), .none(d_none));

  // Entry layout: {valid, none, idx[2:0], onehot[7:0]}
  logic [12:0] a_q[$];
  logic [12:0] b_q[$];
  logic [12:0] c_q[$];
  logic [12:0] d_q[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [12:0] mk(input logic v, input logic n, input logic [2:0] i, input logic [7:0] o);
    return {v, n, i, o};
  endfunction

  function automatic logic [12:0] grant(input int i);
    logic [7:0] o;
    o = 8'd1 << i;
    return mk(1'b1, 1'b0, 3'(i), o);
  endfunction

  task automatic cmp(input string nm, input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got valid=%0b none=%0b idx=%0d onehot=%h, expected valid=%0b none=%0b idx=%0d onehot=%h",
        nm, $time, got[12], got[11], got[10:8], got[7:0], exp[12], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  // Monitor: outputs settle after the rising edge; one queued entry per driven cycle.
  always @(posedge clk) begin
    #1;
    if (a_q.size() > 0) cmp("a_fixed_n4", {a_valid, a_none, 1'b0, a_idx, 4'b0, a_oh}, a_q.pop_front());
    if (b_q.size() > 0) cmp("b_fixed_n8", {b_valid, b_none, b_idx, b_oh}, b_q.pop_front());
    if (c_q.size() > 0) cmp("c_rr_n4",    {c_valid, c_none, 1'b0, c_idx, 4'b0, c_oh}, c_q.pop_front());
    if (d_q.size() > 0) cmp("d_rr_n5",    {d_valid, d_none, d_idx, 3'b0, d_oh}, d_q.pop_front());
  end

  task automatic drive_a(input logic [3:0] r, input logic rdy, input logic [12:0] e);
    @(negedge clk); a_req = r; a_rdy = rdy; a_q.push_back(e);
  endtask
  task automatic drive_b(input logic [7:0] r, input logic rdy, input logic [12:0] e);
    @(negedge clk); b_req = r; b_rdy = rdy; b_q.push_back(e);
  endtask
  task automatic drive_c(input logic rs, input logic [3:0] r, input logic rdy, input logic [12:0] e);
    @(negedge clk); rst = rs; c_req = r; c_rdy = rdy; c_q.push_back(e);
  endtask
  task automatic drive_d(input logic [4:0] r, input logic rdy, input logic [12:0] e);
    @(negedge clk); d_req = r; d_rdy = rdy; d_q.push_back(e);
  endtask

  logic [12:0] rst_exp;
  logic [1:0]  hb [16];
  logic [2:0]  a_prev;
  int          c_seq [6];
  int          d_seq [6];
  int          c_alt [4];

  initial begin
    rst_exp = mk(1'b0, 1'b1, 3'd0, 8'h00);
    // Highest set bit of 0..15, by hand
    hb    = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
    c_seq = '{3, 2, 1, 0, 3, 2};
    d_seq = '{4, 3, 2, 1, 0, 4};
    c_alt = '{3, 0, 3, 0};

    // Reset state on every instance
    @(negedge clk);
    rst = 1'b1;
    a_q.push_back(rst_exp); b_q.push_back(rst_exp); c_q.push_back(rst_exp); d_q.push_back(rst_exp);
    @(negedge clk);
    rst = 1'b0;

    // Fixed priority N=4: sweep all patterns, then an idle sample keeps idx
    a_prev = 3'd0;
    for (int r = 0; r < 16; r++) begin
      if (r == 0) drive_a(4'(r), 1'b1, mk(1'b0, 1'b1, a_prev, 8'h00));
      else begin
        drive_a(4'(r), 1'b1, grant(int'(hb[r])));
        a_prev = 3'(hb[r]);
      end
    end
    drive_a(4'b0000, 1'b1, mk(1'b0, 1'b1, 3'd3, 8'h00));

    // Fixed priority N=8: stall holds grant 7 even after req changes to 8'h02
    drive_b(8'h81, 1'b0, grant(7));
    drive_b(8'h81, 1'b0, grant(7));
    drive_b(8'h81, 1'b0, grant(7));
    drive_b(8'h02, 1'b0, grant(7));
    drive_b(8'h02, 1'b0, grant(7));
    drive_b(8'h02, 1'b0, grant(7));
    drive_b(8'h02, 1'b1, grant(1));
    drive_b(8'h00, 1'b1, mk(1'b0, 1'b1, 3'd1, 8'h00));

    // Round robin N=4, all requesting: rotation with wrap 0 -> 3
    for (int k = 0; k < 6; k++) drive_c(1'b0, 4'b1111, 1'b1, grant(c_seq[k]));
    drive_c(1'b0, 4'b1111, 1'b0, grant(2));
    // Reset while stalled with a valid grant discards it and restores ptr
    drive_c(1'b1, 4'b1111, 1'b0, rst_exp);
    for (int k = 0; k < 4; k++) drive_c(1'b0, 4'b1001, 1'b1, grant(c_alt[k]));
    drive_c(1'b0, 4'b0000, 1'b1, mk(1'b0, 1'b1, 3'd0, 8'h00));

    // Round robin N=5: first grant after reset is 4, mod-5 wrap
    for (int k = 0; k < 6; k++) drive_d(5'b11111, 1'b1, grant(d_seq[k]));
    drive_d(5'b11111, 1'b0, grant(4));
    drive_d(5'b11111, 1'b0, grant(4));
    drive_d(5'b00101, 1'b1, grant(2));
    drive_d(5'b00101, 1'b1, grant(0));
    drive_d(5'b00101, 1'b1, grant(2));
    drive_d(5'b00000, 1'b1, mk(1'b0, 1'b1, 3'd2, 8'h00));
    drive_d(5'b00000, 1'b1, mk(1'b0, 1'b1, 3'd2, 8'h00));
    // ptr is 1 here: search 1, 0, then wraps to 4
    drive_d(5'b10000, 1'b1, grant(4));
    drive_d(5'b00000, 1'b1, mk(1'b0, 1'b1, 3'd4, 8'h00));

    repeat (3) @(negedge clk);
    if (a_q.size() + b_q.size() + c_q.size() + d_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never checked, required 0",
        a_q.size() + b_q.size() + c_q.size() + d_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-input priority encoder; successor to the 4-to-2 combinational encoder.
- Selectable fixed-priority or round-robin arbitration.
- Output side uses a valid/ready handshake so a downstream consumer can stall it.
- Sits between request sources (interrupt lines, channel requests) and a single-issue consumer that needs a binary index.

Parameters:
N, 8, number of request inputs (must be >= 2)
W, $clog2(N), index width (derived; do not override)
MODE, 0, 0 = fixed priority (req[N-1] highest, req[0] lowest); 1 = round-robin

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request vector, sampled on accept cycles only
out_ready  input  1  consumer can take the current result
out_valid  output  1  idx/onehot hold a valid grant
idx  output  W  binary index of the granted request
onehot  output  N  one-hot form of idx; all zero when out_valid=0
none  output  1  registered flag: last sample had req == 0

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, idx=0, onehot=0, none=1, round-robin pointer ptr=N-1.
- Accept condition: load = !out_valid || out_ready.
- On a load cycle, req is sampled and the encoding result is registered on the same edge.
  - Latency is 1 cycle from req to idx/out_valid.
  - Throughput is 1 grant per cycle while out_ready=1.
- Stall: when out_valid=1 and out_ready=0, idx, onehot and out_valid hold. req is ignored, including deassertion of the granted bit. No grant is dropped or changed while stalled.
- Transfer: occurs on any cycle with out_valid=1 and out_ready=1.
- Load result:
  - If req == 0: out_valid<=0, onehot<=0, none<=1, idx holds its previous value.
  - Otherwise: out_valid<=1, none<=0, idx<=selected index g, onehot<=(1<<g).
- MODE=0 selection: g is the highest set bit of req, so req=4'b1011 gives g=3.
- MODE=1 selection:
  - Search starts at ptr and proceeds downward (ptr, ptr-1, ..., 0, N-1, ..., ptr+1, wrapping mod N).
  - g is the first set bit found.
- MODE=1 pointer update:
  - ptr updates only on a transfer: ptr <= (idx_reg == 0) ? N-1 : idx_reg-1.
  - The just-served index becomes lowest priority.
  - A load without a prior transfer (out_valid was 0) does not move ptr.
- Simultaneous transfer and load: the new selection uses the updated ptr combinationally (ptr_next). The back-to-back grant therefore already reflects rotation.
- Wrap-around: the pointer decrement from 0 wraps to N-1. The search wraps across bit 0 to bit N-1.
- Reset mid-operation: rst overrides load and hold in the same cycle. A pending grant is discarded and ptr returns to N-1.
- Non-power-of-2 N: idx values >= N never occur. Search and pointer arithmetic are mod N, not mod 2^W.
- X on req bits of lower priority than the selected bit must not affect idx (matches don't-care inputs of the 4-input encoder).

Test Plan:
- MODE=0, N=4, ready=1; req sweeps 0000..1111 every cycle -> one cycle later idx/onehot/out_valid match highest set bit; req=0000 gives out_valid=0, none=1; req=0110 gives idx=2, onehot=0100.
- MODE=0, N=8, req=8'h81, hold ready=0 for 5 cycles, then change req to 8'h02 -> idx stays 7 and out_valid stays 1 throughout the stall; after ready=1 the next result is idx=1.
- MODE=1, N=4, req=1111 constant, ready=1 -> grant sequence 3,2,1,0,3,2 (ptr wraps 0->3).
- MODE=1, N=4, req=1001 constant, ready=1 -> grants alternate 3,0,3,0; ptr never grants a non-requesting index.
- MODE=1, N=5 (non-power-of-2), req=11111 -> sequence 4,3,2,1,0,4; idx never reaches 5..7.
- Any mode: assert rst for 1 cycle while out_valid=1 and ready=0 -> next cycle out_valid=0, onehot=0, none=1; in MODE=1 the first grant after reset with req=all-ones is N-1.
